// File: rtl/work_serial_tx.sv
// Work-packet UART transmitter: sends midstate then data2, 64 bytes LSB-first,
// as back-to-back 8N1 frames at BAUD on a registered TxD line.
module work_serial_tx #(
    parameter int CLK_FRQ = 100_000_000,
    parameter int BAUD    = 115200
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    output logic         TxD,
    output logic         busy,
    output logic         done
);

    localparam int BIT_CYCLES = CLK_FRQ / BAUD;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [5:0]         byte_q, byte_d;
    logic [511:0]       sh_q, sh_d;
    logic               txd_q, txd_d;
    logic               done_q, done_d;
    logic               bit_end;
    logic [7:0]         cur_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        sh_d     = sh_q;
        done_d   = 1'b0;
        bit_end  = (cnt_q == CNT_MAX);
        cur_byte = 8'h00;
        txd_d    = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = {data2, midstate};
                    byte_d  = '0;
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (byte_q == 6'd63) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        sh_d    = sh_q >> 8;
                        byte_d  = byte_q + 6'd1;
                        state_d = START;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is computed for the state being entered so TxD comes straight off a flop.
        cur_byte = sh_d[7:0];
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = cur_byte[bit_d];
            default: txd_d = 1'b1;
        endcase
    end

    assign TxD  = txd_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_work_serial_tx.sv
// Directed bench for work_serial_tx at 4 clk cycles per bit: packet vectors,
// bit timing, start-while-busy, back-to-back and mid-packet reset.
module tb_work_serial_tx;

    logic         osc_clk = 1'b0;
    logic         reset;
    logic         start;
    logic [255:0] midstate;
    logic [255:0] data2;
    logic         TxD;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    work_serial_tx #(.CLK_FRQ(1_000_000), .BAUD(250_000)) dut (
        .clk      (osc_clk),
        .reset    (reset),
        .start    (start),
        .midstate (midstate),
        .data2    (data2),
        .TxD      (TxD),
        .busy     (busy),
        .done     (done)
    );

    always #5 osc_clk = ~osc_clk;
    always @(posedge osc_clk) cyc <= cyc + 1;

    typedef struct {
        logic [255:0] ms;
        logic [255:0] d2;
        logic [7:0]   b0;
        logic [7:0]   b31;
        logic [7:0]   b32;
        logic [7:0]   b63;
    } vec_t;

    localparam logic [255:0] MS0 =
        256'h6a916935_11223344_55667788_99aabbcc_ddeeff00_0badf00d_deadbeef_536ebbfc;
    localparam logic [255:0] D20 = {128'd0, 32'd0, 32'h1903a30c, 32'd1388185914, 32'he648d53f};

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Entered at the negedge of the first START cycle; returns at the negedge of the done cycle.
    task automatic check_packet(input logic [255:0] ms, input logic [255:0] d2, input int mode,
                                input string name, output logic [511:0] pkt, output int t_done);
        logic [511:0] exp_pkt;
        logic [7:0]   b;
        logic         exp_line;
        int           pos;
        int           wave_bad;
        int           first_bad;
        exp_pkt   = {d2, ms};
        pkt       = '0;
        wave_bad  = 0;
        first_bad = -1;
        for (int k = 0; k < 2560; k++) begin
            b   = exp_pkt[(k/40)*8 +: 8];
            pos = (k % 40) / 4;
            if (pos == 0)      exp_line = 1'b0;
            else if (pos == 9) exp_line = 1'b1;
            else               exp_line = b[pos-1];
            if (TxD !== exp_line || busy !== 1'b1 || done !== 1'b0) begin
                wave_bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (pos >= 1 && pos <= 8 && (k % 4) == 2) pkt[(k/40)*8 + pos - 1] = TxD;
            if (mode == 1) begin
                start = (k == 10 || k == 1000);
                if (k == 5) begin
                    midstate = ~ms;
                    data2    = ~d2;
                end
            end else if (mode == 2) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge osc_clk);
        end
        if (wave_bad != 0) $display("note %s: first bad line cycle %0d", name, first_bad);
        check_int({name, " wave_errs"}, wave_bad, 0);
        check_int({name, " done"}, int'(done), 1);
        check_int({name, " busy_at_done"}, int'(busy), 0);
        check_int({name, " txd_at_done"}, int'(TxD), 1);
        total++;
        if (pkt !== exp_pkt) begin
            bad++;
            $display("FAIL %s decoded: got %h want %h", name, pkt, exp_pkt);
        end
        t_done = cyc;
    endtask

    task automatic pulse_start(input logic [255:0] ms, input logic [255:0] d2);
        midstate = ms;
        data2    = d2;
        start    = 1'b1;
        @(negedge osc_clk);
        start    = 1'b0;
    endtask

    vec_t         vecs[3];
    logic [511:0] pkt;
    int           t1, t2;
    int           seen, bad_idle;
    logic [9:0]   bit_seq;
    int           hold_bad;

    initial begin
        vecs[0] = '{ms: MS0, d2: D20, b0: 8'hfc, b31: 8'h6a, b32: 8'h3f, b63: 8'h00};
        vecs[1] = '{ms: {8'h80, 240'd0, 8'h01}, d2: {8'hA5, 240'd0, 8'h5A},
                    b0: 8'h01, b31: 8'h80, b32: 8'h5A, b63: 8'hA5};
        vecs[2] = '{ms: 256'd0, d2: {256{1'b1}}, b0: 8'h00, b31: 8'h00, b32: 8'hff, b63: 8'hff};

        reset    = 1'b1;
        start    = 1'b0;
        midstate = '0;
        data2    = '0;
        repeat (3) @(negedge osc_clk);
        check_int("reset txd", int'(TxD), 1);
        check_int("reset busy", int'(busy), 0);
        check_int("reset done", int'(done), 0);
        reset = 1'b0;
        repeat (2) @(negedge osc_clk);
        check_int("idle txd", int'(TxD), 1);

        for (int v = 0; v < 3; v++) begin
            pulse_start(vecs[v].ms, vecs[v].d2);
            check_packet(vecs[v].ms, vecs[v].d2, 0, $sformatf("vec%0d", v), pkt, t1);
            check_byte($sformatf("vec%0d byte0", v),  pkt[7:0],     vecs[v].b0);
            check_byte($sformatf("vec%0d byte31", v), pkt[255:248], vecs[v].b31);
            check_byte($sformatf("vec%0d byte32", v), pkt[263:256], vecs[v].b32);
            check_byte($sformatf("vec%0d byte63", v), pkt[511:504], vecs[v].b63);
            @(negedge osc_clk);
            check_int($sformatf("vec%0d done_after", v), int'(done), 0);
        end

        // Byte 0xA5 framed: start, 1,0,1,0,0,1,0,1, stop; listed here last-to-first.
        bit_seq = 10'b1101001010;
        pulse_start({248'd0, 8'hA5}, 256'd0);
        for (int i = 0; i < 10; i++) begin
            hold_bad = 0;
            for (int j = 0; j < 4; j++) begin
                if (TxD !== bit_seq[i]) hold_bad++;
                @(negedge osc_clk);
            end
            check_int($sformatf("a5 bit%0d held_wrong", i), hold_bad, 0);
        end
        seen = 0;
        t1   = -1;
        for (int k = 40; k < 2600; k++) begin
            if (done === 1'b1) begin
                seen++;
                if (t1 < 0) t1 = k;
            end
            @(negedge osc_clk);
        end
        check_int("a5 done_count", seen, 1);
        check_int("a5 done_cycle", t1, 2560);

        pulse_start(MS0, D20);
        check_packet(MS0, D20, 1, "busy_start", pkt, t1);
        @(negedge osc_clk);
        check_int("busy_start done_after", int'(done), 0);
        check_int("busy_start idle_after", int'(busy), 0);

        midstate = MS0;
        data2    = D20;
        start    = 1'b1;
        @(negedge osc_clk);
        check_packet(MS0, D20, 2, "b2b_first", pkt, t1);
        @(negedge osc_clk);
        check_packet(MS0, D20, 0, "b2b_second", pkt, t2);
        check_int("b2b done_gap", t2 - t1, 2561);
        @(negedge osc_clk);

        pulse_start(vecs[1].ms, vecs[1].d2);
        repeat (700) @(negedge osc_clk);
        check_int("pre_reset busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check_int("async_reset txd", int'(TxD), 1);
        check_int("async_reset busy", int'(busy), 0);
        check_int("async_reset done", int'(done), 0);
        repeat (2) @(negedge osc_clk);
        reset    = 1'b0;
        bad_idle = 0;
        for (int k = 0; k < 60; k++) begin
            if (done !== 1'b0 || TxD !== 1'b1 || busy !== 1'b0) bad_idle++;
            @(negedge osc_clk);
        end
        check_int("post_reset idle_errs", bad_idle, 0);
        pulse_start(MS0, D20);
        check_packet(MS0, D20, 0, "post_reset", pkt, t1);
        check_byte("post_reset byte0", pkt[7:0], 8'hfc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
